// File: rtl/mult_product_accumulator_if.sv
// Job-control, product-input and result-output signals of mult_product_accumulator,
// bundled so the accumulator sees one slave port and the producer/consumer one master port.
interface mult_product_accumulator_if #(
  parameter int PROD_WIDTH = 64,
  parameter int ACC_WIDTH  = 72,
  parameter int LEN_WIDTH  = 16
);
  logic                         start;
  logic [LEN_WIDTH-1:0]         len;
  logic                         abort;
  logic                         busy;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [PROD_WIDTH-1:0] in_product;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  out_acc;
  logic [LEN_WIDTH-1:0]         out_count;
  logic                         overflow;

  modport slave (
    input  start, len, abort, in_valid, in_product, out_ready,
    output busy, in_ready, out_valid, out_acc, out_count, overflow
  );

  modport master (
    output start, len, abort, in_valid, in_product, out_ready,
    input  busy, in_ready, out_valid, out_acc, out_count, overflow
  );
endinterface

// File: rtl/mult_product_accumulator.sv
// Sums a programmed number of signed multiplier products into one dot-product result per job.
// Build option MULT_ACC_SATURATE_EN: clamp the accumulator on signed overflow instead of wrapping.
module mult_product_accumulator #(
  parameter int PROD_WIDTH = 64,
  parameter int ACC_WIDTH  = 72,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mult_product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0]        remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]        count_q, count_d;
  logic                        ovf_q, ovf_d;

  logic                        in_ready_s;
  logic                        accept;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] sum_raw;
  logic signed [ACC_WIDTH-1:0] acc_add;
  logic                        add_ovf;

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
    input logic signed [PROD_WIDTH-1:0] p
  );
    return ACC_WIDTH'(p);
  endfunction

  // Two same-signed operands producing an opposite-signed result is the only overflow case.
  function automatic logic add_overflow(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b,
    input logic signed [ACC_WIDTH-1:0] s
  );
    return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

`ifdef MULT_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic neg);
    return neg ? ACC_MIN : ACC_MAX;
  endfunction
`endif

  // Adder stage: sign-extend, add, detect overflow, resolve wrap or clamp
  always_comb begin
    addend  = sext_prod(bus.in_product);
    sum_raw = acc_q + addend;
    add_ovf = add_overflow(acc_q, addend, sum_raw);
`ifdef MULT_ACC_SATURATE_EN
    acc_add = add_ovf ? saturate(addend[ACC_WIDTH-1]) : sum_raw;
`else
    acc_add = sum_raw;
`endif
  end

  assign in_ready_s = (state_q == ACCUM);
  assign accept     = bus.in_valid && in_ready_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // abort outranks start, accept and the result handshake
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    if (bus.abort) begin
      state_d     = IDLE;
      acc_d       = '0;
      remaining_d = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            remaining_d = bus.len;
            state_d     = (bus.len == '0) ? OUTPUT : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d       = acc_add;
            count_d     = count_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            ovf_d       = ovf_q | add_ovf;
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_d = OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result bus reads zero whenever no result is being offered
  always_comb begin
    bus.in_ready  = in_ready_s;
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == OUTPUT);
    bus.out_acc   = (state_q == OUTPUT) ? acc_q : '0;
    bus.out_count = (state_q == OUTPUT) ? count_q : '0;
    bus.overflow  = ovf_q;
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Randomized scoreboard bench for mult_product_accumulator: a 64/72-bit instance and an 8/9-bit
// instance share the stimulus; expected job results come from an integer-arithmetic model.
module tb_mult_product_accumulator;
  localparam int PW = 64, AW = 72, LW = 16, SPW = 8, SAW = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_product_accumulator_if #(.PROD_WIDTH(PW),  .ACC_WIDTH(AW),  .LEN_WIDTH(LW)) big_if ();
  mult_product_accumulator_if #(.PROD_WIDTH(SPW), .ACC_WIDTH(SAW), .LEN_WIDTH(LW)) sm_if ();

  mult_product_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(big_if)
  );
  mult_product_accumulator #(.PROD_WIDTH(SPW), .ACC_WIDTH(SAW), .LEN_WIDTH(LW)) u_sm (
    .clk(clk), .rst_n(rst_n), .bus(sm_if)
  );

  logic                 sel;
  logic                 start, abort, in_valid, oready;
  logic [LW-1:0]        len;
  logic signed [63:0]   prod;
  bit                   rnd_en;

  assign big_if.start      = start & ~sel;
  assign sm_if.start       = start & sel;
  assign big_if.abort      = abort & ~sel;
  assign sm_if.abort       = abort & sel;
  assign big_if.len        = len;
  assign sm_if.len         = len;
  assign big_if.in_valid   = in_valid;
  assign sm_if.in_valid    = in_valid;
  assign big_if.in_product = prod;
  assign sm_if.in_product  = prod[7:0];
  assign big_if.out_ready  = oready;
  assign sm_if.out_ready   = oready;

  wire rdy  = sel ? sm_if.in_ready  : big_if.in_ready;
  wire bsy  = sel ? sm_if.busy      : big_if.busy;
  wire oval = sel ? sm_if.out_valid : big_if.out_valid;

  typedef struct {
    logic signed [127:0] acc;
    int                  cnt;
    bit                  ovf;
  } exp_t;

  exp_t q_big[$];
  exp_t q_sm[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [127:0] got,
                       input logic signed [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Exact integer running sum over a signed range of accw bits; out-of-range steps either wrap
  // by one full span or clamp to the range end, and always raise the flag.
  task automatic model(input logic signed [63:0] p[$], input int accw,
                       output logic signed [127:0] res, output bit ovf);
    logic signed [127:0] mx, mn, span, a, t;
    mx   = (128'sd1 <<< (accw - 1)) - 128'sd1;
    mn   = -mx - 128'sd1;
    span = mx - mn + 128'sd1;
    a    = '0;
    ovf  = 1'b0;
    foreach (p[i]) begin
      t = a + p[i];
      if (t > mx || t < mn) begin
        ovf = 1'b1;
`ifdef MULT_ACC_SATURATE_EN
        a = (t > mx) ? mx : mn;
`else
        a = (t > mx) ? t - span : t + span;
`endif
      end else begin
        a = t;
      end
    end
    res = a;
  endtask

  task automatic push_exp(input bit s, input logic signed [63:0] p[$]);
    exp_t e;
    model(p, s ? SAW : AW, e.acc, e.ovf);
    e.cnt = p.size();
    if (s) q_sm.push_back(e);
    else   q_big.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && big_if.out_valid === 1'b1) begin
      if (q_big.size() == 0) begin
        checks++; errors++;
        $display("FAIL big_unexpected_out_valid got=1 expected=0 at %0t", $time);
      end else begin
        check("big_out_acc",   big_if.out_acc,   q_big[0].acc);
        check("big_out_count", big_if.out_count, q_big[0].cnt);
        check("big_overflow",  big_if.overflow,  q_big[0].ovf);
        if (big_if.out_ready) void'(q_big.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && sm_if.out_valid === 1'b1) begin
      if (q_sm.size() == 0) begin
        checks++; errors++;
        $display("FAIL sm_unexpected_out_valid got=1 expected=0 at %0t", $time);
      end else begin
        check("sm_out_acc",   sm_if.out_acc,   q_sm[0].acc);
        check("sm_out_count", sm_if.out_count, q_sm[0].cnt);
        check("sm_overflow",  sm_if.overflow,  q_sm[0].ovf);
        if (sm_if.out_ready) void'(q_sm.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_en) oready = ($urandom % 3) != 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input bit s, input int n, input logic signed [63:0] p[$],
                         input int gmin, input int gmax, input int abort_at, input int hold);
    bit ok;
    sel = s;
    if (hold > 0) begin
      rnd_en = 0;
      oready = 1'b0;
    end
    start = 1'b1;
    len   = n[LW-1:0];
    tick();
    start = 1'b0;
    if (n == 0) begin
      push_exp(s, p);
      check("zero_len_out_valid", oval, 1);
      in_valid = 1'b1;
      prod     = {$urandom, $urandom};
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        in_valid = 1'b0;
        prod     = {$urandom, $urandom};
        tick();
      end
      in_valid = 1'b1;
      prod     = p[i];
      if (i == abort_at) abort = 1'b1;
      if (i == n - 1 && abort_at < 0) push_exp(s, p);
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        @(negedge clk);
        ok = rdy;
        tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
        checks++; errors++;
        $display("FAIL accept_timeout got=0 expected=1 at %0t", $time);
        rnd_en = 1;
        return;
      end
      if (abort) begin
        abort = 1'b0;
        check("abort_busy", bsy, 0);
        check("abort_out_valid", oval, 0);
        rnd_en = 1;
        return;
      end
    end
    if (n > 0) check("result_latency", oval, 1);
    if (hold > 0) begin
      repeat (hold) tick();
      check("backpressure_hold", oval, 1);
      oready = 1'b1;
    end
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      if (!bsy) ok = 1'b1;
      else tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL job_done_timeout got=busy expected=idle at %0t", $time);
    end
    rnd_en = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running expected=finished at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic signed [63:0] p[$];
    logic signed [7:0]  b;
    int n, ab;
    bit s;

    rst_n = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    oready = 1'b0; len = '0; prod = '0; rnd_en = 1;
    #12;
    check("rst_big_busy",      big_if.busy,      0);
    check("rst_big_in_ready",  big_if.in_ready,  0);
    check("rst_big_out_valid", big_if.out_valid, 0);
    check("rst_big_out_acc",   big_if.out_acc,   0);
    check("rst_big_out_count", big_if.out_count, 0);
    check("rst_big_overflow",  big_if.overflow,  0);
    check("rst_sm_busy",       sm_if.busy,       0);
    check("rst_sm_out_valid",  sm_if.out_valid,  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    rnd_en = 0; oready = 1'b1;
    p = '{64'sd5, -64'sd7, 64'sd100};
    run_job(0, 3, p, 0, 0, -1, 0);

    p = '{64'sh7FFF_FFFF_0000_0001, -64'sd1};
    run_job(0, 2, p, 2, 2, -1, 4);

    p = '{};
    run_job(0, 0, p, 0, 0, -1, 0);
    run_job(1, 0, p, 0, 0, -1, 0);

    p = '{64'sd127, 64'sd127, 64'sd127};
    run_job(1, 3, p, 0, 0, -1, 0);
    p = '{-64'sd128, -64'sd128, -64'sd100};
    run_job(1, 3, p, 0, 1, -1, 0);

    p = '{64'sd11, 64'sd22, 64'sd33, 64'sd44};
    run_job(0, 4, p, 0, 1, 1, 0);
    p = '{-64'sd9};
    run_job(0, 1, p, 0, 0, -1, 0);

    p = '{};
    repeat (300) p.push_back(64'sh7FFF_FFFF_FFFF_FFFF);
    run_job(0, 300, p, 0, 0, -1, 0);
    p = '{};
    repeat (300) p.push_back(64'sh8000_0000_0000_0000);
    run_job(0, 300, p, 0, 0, -1, 2);

    // Async reset in the middle of an ACCUM job
    sel = 1'b0; start = 1'b1; len = 16'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; prod = 64'sd42;
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  big_if.in_ready,  0);
    check("arst_busy",      big_if.busy,      0);
    check("arst_out_valid", big_if.out_valid, 0);
    check("arst_out_acc",   big_if.out_acc,   0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    p = '{-64'sd77};
    run_job(0, 1, p, 0, 0, -1, 0);

    for (int j = 0; j < 60; j++) begin
      s = j[0];
      n = $urandom_range(0, 8);
      p = '{};
      for (int i = 0; i < n; i++) begin
        if (s) begin
          b = 8'($urandom);
          p.push_back(b);
        end else begin
          p.push_back({$urandom, $urandom});
        end
      end
      ab = (n > 0 && ($urandom % 6) == 0) ? $urandom_range(0, n - 1) : -1;
      run_job(s, n, p, 0, 2, ab, 0);
    end

    repeat (3) tick();
    checks++;
    if (q_big.size() != 0 || q_sm.size() != 0) begin
      errors++;
      $display("FAIL results_outstanding got=%0d expected=0", q_big.size() + q_sm.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream consumer of the registered signed multiplier wrapper (32x32 -> 64-bit product, 2-cycle register latency).
- Accumulates a programmed number of signed products into a wide accumulator and emits one dot-product result per job.
- Uses a valid/ready handshake on the input and output sides. This lets multiplier-benchmark runs drive MAC-style traffic.

Parameters:
PROD_WIDTH, 64, width of incoming signed product
ACC_WIDTH, 72, accumulator width (must be >= PROD_WIDTH)
LEN_WIDTH, 16, width of job-length field and term counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a job; sampled only in IDLE
len  input  LEN_WIDTH  number of products in the job; sampled with start
abort  input  1  synchronous job cancel, any state
busy  output  1  high in ACCUM and OUTPUT
in_valid  input  1  in_product is valid
in_ready  output  1  block accepts a product this cycle
in_product  input  PROD_WIDTH  signed product from the multiplier wrapper
out_valid  output  1  out_acc/out_count hold the final job result
out_ready  input  1  downstream consumes the result
out_acc  output  ACC_WIDTH  signed accumulated sum
out_count  output  LEN_WIDTH  number of products actually accumulated
overflow  output  1  sticky signed-overflow flag for the current job

Behaviour:
- One clock domain (clk). Asynchronous active-low reset (rst_n).
- Reset state:
  - state = IDLE; acc = 0; remaining = 0; count = 0.
  - out_valid = 0; in_ready = 0; busy = 0; overflow = 0; out_acc = 0; out_count = 0.
  - Reset mid-job discards everything immediately.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready = 0, busy = 0.
  - start with len != 0 -> ACCUM. Load remaining = len; clear acc, count and overflow.
  - start with len == 0 -> OUTPUT. acc = 0, count = 0, overflow = 0.
- ACCUM:
  - in_ready = 1 combinationally from state (does not depend on in_valid).
  - Accept when in_valid && in_ready:
    - acc <= acc + sign_extend(in_product)
    - count += 1; remaining -= 1
  - Accept with remaining == 1 -> OUTPUT next cycle.
  - No accept -> hold all state.
- OUTPUT:
  - out_valid = 1; out_acc and out_count driven from registers.
  - Values stay stable until out_valid && out_ready, then -> IDLE.
  - start is ignored in OUTPUT; a new job can begin at the earliest one cycle after the handshake.
- Latency: out_valid rises exactly 1 cycle after the final product is accepted. Full throughput is 1 product/cycle in ACCUM.
- Overflow detection: signed overflow of the ACC_WIDTH add (addend sign equal, result sign differs). Sets overflow, which stays sticky until the next start.
- abort:
  - Has priority over every other event, including a same-cycle accept or out handshake.
  - Next cycle: state = IDLE, acc/count/overflow cleared, out_valid = 0.
  - A product offered in the abort cycle is not counted.
- Simultaneous events:
  - start && abort in IDLE -> stay IDLE.
  - out_ready without out_valid has no effect.
  - in_valid outside ACCUM is ignored (in_ready = 0).
- Arithmetic: two's complement throughout. Products are sign-extended from PROD_WIDTH to ACC_WIDTH.

Optional Feature:
- Macro: MULT_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to the signed max (positive overflow) or signed min (negative overflow) of ACC_WIDTH. Later adds proceed from the clamped value. overflow is still set.
- Undefined: acc wraps modulo 2^ACC_WIDTH. overflow is still set.

Test Plan:
- Basic job: len=3, products 5, -7, 100 back-to-back, out_ready=1 -> out_valid 1 cycle after 3rd accept, out_acc=98, out_count=3, overflow=0, then busy=0.
- Gapped input + backpressure: len=2, products 0x7FFF_FFFF_0000_0001 then -1 with 2 idle cycles between; out_ready held low 4 cycles -> out_acc=0x7FFF_FFFF_0000_0000 held stable, cleared after handshake.
- Zero-length job: start, len=0 -> OUTPUT next cycle with out_acc=0, out_count=0; in_valid pulses during the job are ignored.
- Overflow (PROD_WIDTH=8, ACC_WIDTH=9): len=3, products 127, 127, 127:
  - Wrap build: out_acc = 381 mod 512 = -131, overflow=1.
  - MULT_ACC_SATURATE_EN build: out_acc = 255, overflow=1.
- Abort: len=4, abort on the cycle the 2nd product is accepted -> IDLE next cycle, out_valid never asserts. A following job with len=1 and product -9 yields out_acc=-9, out_count=1, overflow=0.
- Async reset mid-ACCUM: assert rst_n=0 between clock edges -> in_ready, busy and out_valid drop immediately, out_acc=0. After release, start with len=1 works normally.
